// File: rtl/vliw_regfile_pkg.sv
// Shared types and constants for the STARBUG VLIW register file.
// Holds the core configuration struct, lane count, lane index type and conflict counter sizing.
package vliw_regfile_pkg;

  typedef struct packed {
    int unsigned XLEN;
    logic        E_SUPPORTED;
  } cvw_t;

  localparam cvw_t RF_CFG_DEFAULT = '{XLEN: 32, E_SUPPORTED: 1'b0};

  localparam int VLIW_NLANES = 4;
  typedef logic [$clog2(VLIW_NLANES)-1:0] lane_idx_t;

  localparam int                        CONFLICT_CNT_W   = 16;
  localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = '1;

  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(input logic [CONFLICT_CNT_W-1:0] v);
    return (v == CONFLICT_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vliw_wrsel.sv
// Winner selection for one register address over all lanes' effective writes.
// Highest matching lane wins; o_multi flags two or more lanes hitting the same address.
module vliw_wrsel
  import vliw_regfile_pkg::*;
#(
  parameter int NLANES = VLIW_NLANES
) (
  input  logic [4:0]                  i_addr,
  input  logic [NLANES-1:0]           i_we,
  input  logic [NLANES-1:0][4:0]      i_a3,
  output logic                        o_hit,
  output logic                        o_multi,
  output logic [$clog2(NLANES)-1:0]   o_lane
);

  localparam int LW = $clog2(NLANES);

  always_comb begin
    o_hit   = 1'b0;
    o_multi = 1'b0;
    o_lane  = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (i_we[i] && (i_a3[i] == i_addr)) begin
        o_multi = o_multi | o_hit;
        o_hit   = 1'b1;
        o_lane  = LW'(i);
      end
    end
  end

endmodule

// File: rtl/vliw_regfile.sv
// Shared multi-ported integer register file for the STARBUG VLIW core with slot-priority writes.
// Optional same-cycle Writeback-to-Decode bypass is enabled by defining VLIW_RF_BYPASS_EN.
module vliw_regfile
  import vliw_regfile_pkg::*;
#(
  parameter cvw_t P      = RF_CFG_DEFAULT,
  parameter int   NLANES = VLIW_NLANES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NLANES-1:0]                  we3,
  input  logic [NLANES-1:0][4:0]             a1,
  input  logic [NLANES-1:0][4:0]             a2,
  input  logic [NLANES-1:0][4:0]             a3,
  input  logic [NLANES-1:0][P.XLEN-1:0]      wd3,
  output logic [NLANES-1:0][P.XLEN-1:0]      rd1,
  output logic [NLANES-1:0][P.XLEN-1:0]      rd2,
  input  logic                               ClearCount,
  output logic                               WriteConflict,
  output logic [CONFLICT_CNT_W-1:0]          ConflictCount
);

  localparam int XLEN   = P.XLEN;
  localparam int NREGS  = P.E_SUPPORTED ? 16 : 32;
  localparam int RIDX_W = P.E_SUPPORTED ? 4 : 5;
  localparam int LW     = $clog2(NLANES);

  logic [XLEN-1:0]           r_regs [1:NREGS-1];
  logic                      r_conflict;
  logic [CONFLICT_CNT_W-1:0] r_count;

  logic [NLANES-1:0] w_we_eff;
  logic [NREGS-1:1]  w_reg_hit;
  logic [NREGS-1:1]  w_reg_multi;
  logic [LW-1:0]     w_reg_lane [1:NREGS-1];
  logic              w_coll;

  // Writes to x0, to the absent upper half in E mode, or during reset never reach storage.
  always_comb begin
    w_we_eff = '0;
    for (int l = 0; l < NLANES; l++) begin
      w_we_eff[l] = we3[l] & (a3[l] != 5'd0) & ~reset & ~(P.E_SUPPORTED & a3[l][4]);
    end
  end

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    vliw_wrsel #(.NLANES(NLANES)) u_sel (
      .i_addr  (5'(r)),
      .i_we    (w_we_eff),
      .i_a3    (a3),
      .o_hit   (w_reg_hit[r]),
      .o_multi (w_reg_multi[r]),
      .o_lane  (w_reg_lane[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w_reg_hit[r]) r_regs[r] <= wd3[w_reg_lane[r]];
      end
    end
  end

`ifdef VLIW_RF_BYPASS_EN
  logic [NLANES-1:0] w_bp1_hit, w_bp2_hit;
  logic [NLANES-1:0] w_bp1_multi, w_bp2_multi;
  logic [LW-1:0]     w_bp1_lane [NLANES];
  logic [LW-1:0]     w_bp2_lane [NLANES];

  for (genvar l = 0; l < NLANES; l++) begin : g_bp
    vliw_wrsel #(.NLANES(NLANES)) u_bp1 (
      .i_addr  (a1[l]),
      .i_we    (w_we_eff),
      .i_a3    (a3),
      .o_hit   (w_bp1_hit[l]),
      .o_multi (w_bp1_multi[l]),
      .o_lane  (w_bp1_lane[l])
    );
    vliw_wrsel #(.NLANES(NLANES)) u_bp2 (
      .i_addr  (a2[l]),
      .i_we    (w_we_eff),
      .i_a3    (a3),
      .o_hit   (w_bp2_hit[l]),
      .o_multi (w_bp2_multi[l]),
      .o_lane  (w_bp2_lane[l])
    );
  end

  // A read port seeing multiple writers implies a register collision, so OR-ing it in is harmless.
  assign w_coll = (|w_reg_multi) | (|w_bp1_multi) | (|w_bp2_multi);
`else
  assign w_coll = |w_reg_multi;
`endif

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int l = 0; l < NLANES; l++) begin
      if (!reset && (a1[l] != 5'd0) && !(P.E_SUPPORTED && a1[l][4])) begin
        rd1[l] = r_regs[RIDX_W'(a1[l])];
`ifdef VLIW_RF_BYPASS_EN
        if (w_bp1_hit[l]) rd1[l] = wd3[w_bp1_lane[l]];
`endif
      end
      if (!reset && (a2[l] != 5'd0) && !(P.E_SUPPORTED && a2[l][4])) begin
        rd2[l] = r_regs[RIDX_W'(a2[l])];
`ifdef VLIW_RF_BYPASS_EN
        if (w_bp2_hit[l]) rd2[l] = wd3[w_bp2_lane[l]];
`endif
      end
    end
  end

  // ClearCount beats a simultaneous collision increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict <= 1'b0;
      r_count    <= '0;
    end else begin
      r_conflict <= w_coll;
      if (ClearCount)  r_count <= '0;
      else if (w_coll) r_count <= sat_inc(r_count);
    end
  end

  assign WriteConflict = r_conflict;
  assign ConflictCount = r_count;

endmodule
